prog_loader: RTL and testbench

Upstream boot stage for the RISC core. It receives a framed byte stream from a host over a valid/ready link and writes the payload into program memory through a dedicated write port. It holds the core in reset during loading and releases it only after the checksum verifies. After the core halts, it can accept a new frame to reload the program.

---
 rtl/prog_loader_if.sv | 27 ++
 rtl/prog_loader.sv | 177 +++++++++++++++++
 tb/tb_prog_loader.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - host byte link, core control and program-memory write port of the loader
interface prog_loader_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] host_data;
    logic              host_valid;
    logic              host_ready;
    logic              halt;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_wr;
    logic              core_rst;
    logic              busy;
    logic              load_done;
    logic              err;

    modport master (
        output host_data, host_valid, halt,
        input  host_ready, ld_addr, ld_data, ld_wr, core_rst, busy, load_done, err
    );

    modport slave (
        input  host_data, host_valid, halt,
        output host_ready, ld_addr, ld_data, ld_wr, core_rst, busy, load_done, err
    );
endinterface

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte-stream program loader holding the core in reset until checksum passes
module prog_loader #(
    parameter int ADDR_W   = 13,
    parameter int DATA_W   = 8,
    parameter int RST_HOLD = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    prog_loader_if.slave  bus
);
    localparam int LEN_W  = 2 * DATA_W;
    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [DATA_W-1:0] SYNC    = DATA_W'(8'hA5);
    localparam logic [LEN_W-1:0]  MAX_LEN = LEN_W'(1 << ADDR_W);
    localparam logic [HOLD_W-1:0] HOLD_END = HOLD_W'(RST_HOLD - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR_H,
        S_ADDR_L,
        S_LEN_H,
        S_LEN_L,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_RELEASE,
        S_RUN,
        S_ERROR
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   len_hi_q, len_hi_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   csum_q, csum_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [ADDR_W-1:0]   ld_addr_q, ld_addr_d;
    logic [DATA_W-1:0]   ld_data_q, ld_data_d;

    logic                ready_s;
    logic                xfer;
    logic [DATA_W-1:0]   sum_nxt;
    logic [LEN_W-1:0]    len_full;

    // In RUN the link only opens once the core has halted.
    always_comb begin
        ready_s = 1'b0;
        unique case (state_q)
            S_IDLE, S_ADDR_H, S_ADDR_L, S_LEN_H, S_LEN_L,
            S_DATA, S_CSUM, S_ERROR: ready_s = 1'b1;
            S_RUN:                   ready_s = bus.halt;
            default:                 ready_s = 1'b0;
        endcase
    end

    assign bus.host_ready = ready_s && !rst_i;
    assign xfer           = bus.host_valid && bus.host_ready;
    assign sum_nxt        = csum_q + bus.host_data;
    assign len_full       = {len_hi_q, bus.host_data};

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_hi_d  = len_hi_q;
        cnt_d     = cnt_q;
        csum_d    = csum_q;
        hold_d    = hold_q;
        ld_addr_d = ld_addr_q;
        ld_data_d = ld_data_q;

        unique case (state_q)
            S_IDLE, S_RUN, S_ERROR: begin
                if (xfer && bus.host_data == SYNC) begin
                    csum_d  = SYNC;
                    state_d = S_ADDR_H;
                end
            end
            S_ADDR_H: begin
                if (xfer) begin
                    addr_d[ADDR_W-1:DATA_W] = bus.host_data[ADDR_W-DATA_W-1:0];
                    csum_d  = sum_nxt;
                    state_d = S_ADDR_L;
                end
            end
            S_ADDR_L: begin
                if (xfer) begin
                    addr_d[DATA_W-1:0] = bus.host_data;
                    csum_d  = sum_nxt;
                    state_d = S_LEN_H;
                end
            end
            S_LEN_H: begin
                if (xfer) begin
                    len_hi_d = bus.host_data;
                    csum_d   = sum_nxt;
                    state_d  = S_LEN_L;
                end
            end
            S_LEN_L: begin
                if (xfer) begin
                    cnt_d  = len_full;
                    csum_d = sum_nxt;
                    if (len_full > MAX_LEN) begin
                        state_d = S_ERROR;
                    end else if (len_full == '0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    ld_data_d = bus.host_data;
                    ld_addr_d = addr_q;
                    csum_d    = sum_nxt;
                    state_d   = S_WRITE;
                end
            end
            S_WRITE: begin
                // Address wraps naturally at the top of the ADDR_W space.
                addr_d  = addr_q + ADDR_W'(1);
                cnt_d   = cnt_q - LEN_W'(1);
                state_d = (cnt_q == LEN_W'(1)) ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
                if (xfer) begin
                    csum_d  = sum_nxt;
                    hold_d  = '0;
                    state_d = (sum_nxt == '0) ? S_RELEASE : S_ERROR;
                end
            end
            S_RELEASE: begin
                if (hold_q == HOLD_END) begin
                    state_d = S_RUN;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            len_hi_q  <= '0;
            cnt_q     <= '0;
            csum_q    <= '0;
            hold_q    <= '0;
            ld_addr_q <= '0;
            ld_data_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_hi_q  <= len_hi_d;
            cnt_q     <= cnt_d;
            csum_q    <= csum_d;
            hold_q    <= hold_d;
            ld_addr_q <= ld_addr_d;
            ld_data_q <= ld_data_d;
        end
    end

    // ERROR and RUN are only left through ADDR_H, so err/load_done follow the state directly.
    assign bus.ld_addr   = ld_addr_q;
    assign bus.ld_data   = ld_data_q;
    assign bus.ld_wr     = (state_q == S_WRITE);
    assign bus.core_rst  = (state_q != S_RUN);
    assign bus.load_done = (state_q == S_RUN);
    assign bus.err       = (state_q == S_ERROR);
    assign bus.busy      = (state_q == S_ADDR_H) || (state_q == S_ADDR_L) ||
                           (state_q == S_LEN_H)  || (state_q == S_LEN_L)  ||
                           (state_q == S_DATA)   || (state_q == S_WRITE)  ||
                           (state_q == S_CSUM)   || (state_q == S_RELEASE);
endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - randomized scoreboard bench for prog_loader against a frame-level model
module tb_prog_loader;
    localparam int RST_HOLD = 4;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [12:0] a;
        logic [7:0]  d;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prog_loader_if #(.ADDR_W(13), .DATA_W(8)) bus ();

    prog_loader #(.ADDR_W(13), .DATA_W(8), .RST_HOLD(RST_HOLD)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int  n_checks = 0;
    int  n_fail   = 0;
    wr_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the next expected write.
    always @(negedge clk) begin : monitor
        wr_t e;
        if (bus.ld_wr === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                         bus.ld_addr, bus.ld_data);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", 32'(bus.ld_addr), 32'(e.a));
                chk("write_data", 32'(bus.ld_data), 32'(e.d));
            end
        end
    end

    // Reference model: 0 = good load, 1 = bad checksum, 2 = length overflow.
    task automatic model_frame(input bq_t f, output int outcome);
        int  addr;
        int  len;
        int  sum;
        wr_t w;
        addr = ((int'(f[1]) & 31) * 256) + int'(f[2]);
        len  = int'(f[3]) * 256 + int'(f[4]);
        if (len > 8192) begin
            outcome = 2;
            return;
        end
        for (int i = 0; i < len; i++) begin
            w.a = 13'((addr + i) % 8192);
            w.d = f[5 + i];
            exp_q.push_back(w);
        end
        sum = 0;
        foreach (f[i]) sum += int'(f[i]);
        outcome = (sum % 256 == 0) ? 0 : 1;
    endtask

    function automatic bq_t rand_pay(input int len);
        bq_t p;
        for (int i = 0; i < len; i++) p.push_back(8'($urandom));
        return p;
    endfunction

    function automatic bq_t make_frame(input int addr, input bq_t pay, input bit bad);
        bq_t f;
        int  sum;
        f.push_back(8'hA5);
        f.push_back(8'(($urandom_range(0, 7) << 5) | ((addr >> 8) & 31)));
        f.push_back(8'(addr & 255));
        f.push_back(8'(pay.size() >> 8));
        f.push_back(8'(pay.size() & 255));
        foreach (pay[i]) f.push_back(pay[i]);
        sum = 0;
        foreach (f[i]) sum += int'(f[i]);
        sum = (256 - (sum % 256)) % 256;
        if (bad) sum = (sum + $urandom_range(1, 255)) % 256;
        f.push_back(8'(sum));
        return f;
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit jit);
        int cyc;
        bit acc;
        cyc = 0;
        acc = 1'b0;
        if (jit) begin
            while ($urandom_range(0, 2) == 0) begin
                bus.host_valid = 1'b0;
                bus.host_data  = 8'($urandom);
                @(negedge clk);
            end
        end
        bus.host_data  = b;
        bus.host_valid = 1'b1;
        do begin
            #1;
            acc = bus.host_ready;
            @(negedge clk);
            cyc++;
        end while (!acc && cyc < 200);
        bus.host_valid = 1'b0;
        if (!acc) chk("handshake_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_bytes(input bq_t f, input int start, input bit jit);
        for (int i = start; i < f.size(); i++) send_byte(f[i], jit);
    endtask

    task automatic post_check(input int outcome);
        int n;
        if (outcome == 0) begin
            n = 0;
            while (bus.core_rst && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("release_latency", 32'(n), 32'(RST_HOLD));
            chk("run_core_rst", 32'(bus.core_rst), 32'd0);
            chk("run_load_done", 32'(bus.load_done), 32'd1);
            chk("run_err", 32'(bus.err), 32'd0);
            chk("run_busy", 32'(bus.busy), 32'd0);
        end else begin
            @(negedge clk);
            chk("error_err", 32'(bus.err), 32'd1);
            chk("error_core_rst", 32'(bus.core_rst), 32'd1);
            chk("error_load_done", 32'(bus.load_done), 32'd0);
            chk("error_busy", 32'(bus.busy), 32'd0);
        end
        chk("writes_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_frame(input bq_t f, input bit jit);
        int outcome;
        model_frame(f, outcome);
        send_bytes(f, 0, jit);
        post_check(outcome);
    endtask

    task automatic chk_reset_vals(input string tag);
        #1;
        chk({tag, "_core_rst"}, 32'(bus.core_rst), 32'd1);
        chk({tag, "_ld_wr"}, 32'(bus.ld_wr), 32'd0);
        chk({tag, "_ld_addr"}, 32'(bus.ld_addr), 32'd0);
        chk({tag, "_ld_data"}, 32'(bus.ld_data), 32'd0);
        chk({tag, "_host_ready"}, 32'(bus.host_ready), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_load_done"}, 32'(bus.load_done), 32'd0);
        chk({tag, "_err"}, 32'(bus.err), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t f;
        int  outcome;
        bus.host_data  = 8'h00;
        bus.host_valid = 1'b0;
        bus.halt       = 1'b1;
        rst            = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);

        f = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'hF1};
        run_frame(f, 1'b0);
        f = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'hF0};
        run_frame(f, 1'b0);
        run_frame(make_frame(int'($urandom_range(0, 8191)), rand_pay(5), 1'b0), 1'b0);

        f = '{8'hAA, 8'hBB};
        run_frame(make_frame(13'h1FFF, f, 1'b0), 1'b0);
        f = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h00, 8'h4B};
        run_frame(f, 1'b0);
        f = '{8'hA5, 8'h00, 8'h00, 8'h20, 8'h01};
        run_frame(f, 1'b0);
        run_frame(make_frame(int'($urandom_range(0, 8191)), rand_pay(3), 1'b0), 1'b0);

        // Reload gating: sync byte waits while the core runs, accepted once halted.
        f = make_frame(int'($urandom_range(0, 8191)), rand_pay(4), 1'b0);
        model_frame(f, outcome);
        bus.halt       = 1'b0;
        bus.host_data  = 8'hA5;
        bus.host_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("gate_ready", 32'(bus.host_ready), 32'd0);
            chk("gate_core_rst", 32'(bus.core_rst), 32'd0);
            @(negedge clk);
        end
        bus.halt = 1'b1;
        send_byte(f[0], 1'b0);
        chk("reload_core_rst", 32'(bus.core_rst), 32'd1);
        chk("reload_busy", 32'(bus.busy), 32'd1);
        chk("reload_load_done", 32'(bus.load_done), 32'd0);
        send_bytes(f, 1, 1'b0);
        post_check(outcome);

        run_frame(make_frame(int'($urandom_range(0, 8191)), rand_pay(16), 1'b0), 1'b1);
        for (int k = 0; k < 6; k++) begin
            run_frame(make_frame(int'($urandom_range(0, 8191)),
                                 rand_pay(int'($urandom_range(1, 20))),
                                 ($urandom_range(0, 3) == 0)), 1'b1);
        end

        // Reset mid-frame after two payload bytes.
        f = make_frame(int'($urandom_range(0, 8191)), rand_pay(6), 1'b0);
        model_frame(f, outcome);
        for (int i = 0; i < 7; i++) send_byte(f[i], 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_writes_done", 32'(exp_q.size()), 32'd4);
        exp_q.delete();
        chk_reset_vals("abort");
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_frame(make_frame(int'($urandom_range(0, 8191)), rand_pay(7), 1'b0), 1'b1);

        repeat (5) @(negedge clk);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
